// File: rtl/simon_pkg.sv
// Shared types and sizing for the Simon Says playback engine.
package simon_pkg;

    localparam int unsigned DATA_W  = 6;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned MAX_LEN = 32;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        SHOW,
        GAP,
        DONE
    } play_state_t;

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; expired is high once the count has reached zero.
module cycle_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             expired
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= value;
        end else if (count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/simon_playback.sv
// Plays back stored Simon patterns: read each entry, show it, blank, then pulse done.
module simon_playback #(
    parameter int unsigned DATA_W      = 6,
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned ON_CYCLES   = 12500000,
    parameter int unsigned OFF_CYCLES  = 6250000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   seq_len,
    output logic [ADDR_W-1:0] r_ptr,
    output logic              r_en,
    input  logic [DATA_W-1:0] data_Out,
    output logic [DATA_W-1:0] led_out,
    output logic              busy,
    output logic              done
);

    import simon_pkg::*;

    localparam int unsigned OnOffMax = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int unsigned TmrMax   = (OnOffMax > MEM_LATENCY) ? OnOffMax : MEM_LATENCY;
    localparam int unsigned TmrW     = $clog2(TmrMax + 1);

    // Timer loads count-1 so that it reports expired on the last cycle of the state.
    localparam logic [TmrW-1:0] WaitLoad = TmrW'(MEM_LATENCY - 1);
    localparam logic [TmrW-1:0] OnLoad   = TmrW'(ON_CYCLES - 1);
    localparam logic [TmrW-1:0] OffLoad  = TmrW'(OFF_CYCLES - 1);
    localparam logic [ADDR_W:0] LenMax   = (ADDR_W + 1)'(MAX_LEN);

    play_state_t       state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   len_clamped;
    logic [DATA_W-1:0] led_d;
    logic [ADDR_W-1:0] r_ptr_d;
    logic              r_en_d, done_d, busy_d;
    logic              tmr_load, tmr_expired;
    logic [TmrW-1:0]   tmr_value;

    cycle_timer #(
        .WIDTH(TmrW)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (tmr_load),
        .value  (tmr_value),
        .expired(tmr_expired)
    );

    assign len_clamped = (seq_len > LenMax) ? LenMax : seq_len;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        led_d     = led_out;
        r_ptr_d   = r_ptr;
        r_en_d    = 1'b0;
        done_d    = 1'b0;
        tmr_load  = 1'b0;
        tmr_value = '0;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    len_d = len_clamped;
                    if (len_clamped == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = '0;
                        r_ptr_d = '0;
                        r_en_d  = 1'b1;
                        state_d = READ;
                    end
                end
            end
            READ: begin
                state_d   = WAIT;
                tmr_load  = 1'b1;
                tmr_value = WaitLoad;
            end
            WAIT: begin
                // The LED register doubles as the captured pattern for the SHOW phase.
                if (tmr_expired) begin
                    led_d     = data_Out;
                    state_d   = SHOW;
                    tmr_load  = 1'b1;
                    tmr_value = OnLoad;
                end
            end
            SHOW: begin
                if (tmr_expired) begin
                    led_d     = '0;
                    state_d   = GAP;
                    tmr_load  = 1'b1;
                    tmr_value = OffLoad;
                end
            end
            GAP: begin
                if (tmr_expired) begin
                    if (({1'b0, idx_q} + (ADDR_W + 1)'(1)) == len_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        r_ptr_d = idx_q + ADDR_W'(1);
                        r_en_d  = 1'b1;
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            led_d   = '0;
            r_en_d  = 1'b0;
            done_d  = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            r_ptr   <= '0;
            r_en    <= 1'b0;
            led_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            r_ptr   <= r_ptr_d;
            r_en    <= r_en_d;
            led_out <= led_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_simon_playback.sv
// Directed bench for simon_playback with a registered-read memory model and per-cycle scoreboard.
module tb_simon_playback;

    localparam int unsigned DW  = 6;
    localparam int unsigned AW  = 5;
    localparam int unsigned ON  = 4;
    localparam int unsigned OFF = 2;

    logic          clk;
    logic          reset;
    logic          start;
    logic          abort;
    logic [AW:0]   seq_len;
    logic [AW-1:0] r_ptr;
    logic          r_en;
    logic [DW-1:0] data_Out;
    logic [DW-1:0] led_out;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [DW-1:0] led;
        logic          r_en;
        logic [AW-1:0] r_ptr;
        logic          busy;
        logic          done;
    } exp_t;

    exp_t exp_q[$];

    logic [DW-1:0] mem [32];
    logic [DW-1:0] mem_rd;

    simon_playback #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .MEM_LATENCY(1),
        .ON_CYCLES  (ON),
        .OFF_CYCLES (OFF)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .abort   (abort),
        .seq_len (seq_len),
        .r_ptr   (r_ptr),
        .r_en    (r_en),
        .data_Out(data_Out),
        .led_out (led_out),
        .busy    (busy),
        .done    (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] pat(input int i);
        logic [DW-1:0] one;
        one = 1;
        return one << (i % 6);
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = pat(i);
    end

    always @(posedge clk) begin
        if (r_en) mem_rd <= mem[r_ptr];
    end
    assign data_Out = mem_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_item(input logic [DW-1:0] led, input logic ren, input int ptr,
                             input logic bsy, input logic dn);
        exp_t e;
        e.led   = led;
        e.r_en  = ren;
        e.r_ptr = AW'(ptr);
        e.busy  = bsy;
        e.done  = dn;
        exp_q.push_back(e);
    endtask

    // Expected per-cycle trace of a complete run, starting the cycle after start is sampled.
    task automatic push_run(input int len);
        int l;
        l = (len > 32) ? 32 : len;
        for (int i = 0; i < l; i++) begin
            push_item('0, 1'b1, i, 1'b1, 1'b0);
            push_item('0, 1'b0, 0, 1'b1, 1'b0);
            for (int k = 0; k < ON; k++) push_item(pat(i), 1'b0, 0, 1'b1, 1'b0);
            for (int k = 0; k < OFF; k++) push_item('0, 1'b0, 0, 1'b1, 1'b0);
        end
        push_item('0, 1'b0, 0, 1'b1, 1'b1);
        push_item('0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic push_idle(input int n);
        for (int k = 0; k < n; k++) push_item('0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    // Compare n cycles at negedge, leaving time at the negedge of the next cycle.
    task automatic consume(input string tag, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            if (exp_q.size() == 0) begin
                check($sformatf("%s[%0d] scoreboard_empty", tag, k), 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("%s[%0d] led_out", tag, k), 32'(led_out), 32'(e.led));
                check($sformatf("%s[%0d] r_en", tag, k), 32'(r_en), 32'(e.r_en));
                if (e.r_en) check($sformatf("%s[%0d] r_ptr", tag, k), 32'(r_ptr), 32'(e.r_ptr));
                check($sformatf("%s[%0d] busy", tag, k), 32'(busy), 32'(e.busy));
                check($sformatf("%s[%0d] done", tag, k), 32'(done), 32'(e.done));
            end
            @(negedge clk);
        end
    endtask

    // Called at a negedge; start is sampled by the following posedge.
    task automatic begin_run(input int len);
        start   = 1'b1;
        seq_len = (AW + 1)'(len);
        push_run(len);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        seq_len = '0;
        repeat (3) @(negedge clk);
        check("reset led_out", 32'(led_out), 32'd0);
        check("reset r_en", 32'(r_en), 32'd0);
        check("reset r_ptr", 32'(r_ptr), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Three entries: done lands 25 cycles after the start edge.
        begin_run(3);
        consume("len3", 26);

        begin_run(0);
        consume("len0", 2);
        push_idle(2);
        consume("len0_idle", 2);

        // Oversized length clamps to 32 entries, r_ptr 0..31.
        begin_run(40);
        consume("len40", 32 * 8 + 2);

        // Abort in the second SHOW cycle of entry 1.
        begin_run(5);
        consume("abort_pre", 11);
        abort = 1'b1;
        consume("abort_pre", 1);
        abort = 1'b0;
        exp_q.delete();
        push_idle(3);
        consume("abort_post", 3);
        begin_run(1);
        consume("after_abort", 10);

        // abort together with start in IDLE keeps the engine idle.
        start   = 1'b1;
        abort   = 1'b1;
        seq_len = 3;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        push_idle(3);
        consume("abort_start", 3);

        // Second start and seq_len change mid-run are ignored.
        begin_run(2);
        consume("restart_ign", 5);
        start   = 1'b1;
        seq_len = 5;
        consume("restart_ign", 1);
        start = 1'b0;
        consume("restart_ign", 12);
        push_idle(3);
        consume("restart_tail", 3);

        // Reset in the GAP of entry 1.
        begin_run(3);
        consume("rst_pre", 14);
        reset = 1'b1;
        consume("rst_pre", 1);
        reset = 1'b0;
        exp_q.delete();
        check("rst_mid r_ptr", 32'(r_ptr), 32'd0);
        push_idle(2);
        consume("rst_post", 2);
        begin_run(2);
        consume("rst_restart", 18);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/simon_playback.md
Name: simon_playback

Overview:
- Downstream consumer of the Simon Says pattern `memory` block.
- On command, it walks memory entries 0..len-1 over the memory read port (r_ptr/r_en/data_Out).
- It shows each stored 6-bit pattern on led_out for a fixed on-time, then blanks the LEDs for a fixed gap.
- It pulses done when the whole sequence has been shown; the game FSM uses this as the "Simon's turn" playback engine.

Parameters:
- DATA_W, 6, width of a stored pattern / LED vector (matches memory data_In/data_Out).
- ADDR_W, 5, memory pointer width (32 entries).
- MEM_LATENCY, 1, clocks from r_en sampled to data_Out valid (memory read is registered).
- ON_CYCLES, 12500000, clocks each pattern is shown; must be >= 1.
- OFF_CYCLES, 6250000, blank clocks after each pattern; must be >= 1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin playback; ignored unless idle.
- abort  in  1  cancel playback; takes priority over everything except reset.
- seq_len  in  ADDR_W+1  number of entries to play, 0..32; values >32 clamp to 32.
- r_ptr  out  ADDR_W  memory read address (registered).
- r_en  out  1  memory read enable (registered, one-cycle pulse per entry).
- data_Out  in  DATA_W  memory read data.
- led_out  out  DATA_W  pattern currently displayed; 0 when blank.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when playback completes normally.

Behaviour:
- Reset (synchronous, active-high):
  - Next state is IDLE.
  - r_ptr=0, r_en=0, led_out=0, busy=0, done=0; idx, len_q and timer cleared.
- States and transitions:
  - IDLE: on start, latch len_q=clamp(seq_len). If len_q==0, go to DONE; else set idx=0 and go to READ.
  - READ: exactly 1 cycle; r_en=1, r_ptr=idx; go to WAIT.
  - WAIT: MEM_LATENCY cycles with r_en=0. On the final WAIT cycle, capture data_Out into pat_q; go to SHOW.
  - SHOW: led_out=pat_q for ON_CYCLES cycles; go to GAP.
  - GAP: led_out=0 for OFF_CYCLES cycles. Then if idx+1==len_q go to DONE, else idx++ and go to READ.
  - DONE: done=1 for exactly 1 cycle, led_out=0; go to IDLE.
- Per-entry time is 1+MEM_LATENCY+ON_CYCLES+OFF_CYCLES clocks.
- done is asserted in the cycle len_q*(1+MEM_LATENCY+ON_CYCLES+OFF_CYCLES)+1 after the start-sampling edge; for len 0, it is asserted the cycle after start.
- All outputs are registered. led_out changes only on SHOW entry and GAP entry.
- start while busy is ignored; the sequence in progress is unaffected and seq_len is not re-sampled.
- abort in any non-IDLE state:
  - Next state is IDLE; led_out=0, r_en=0, done stays 0.
  - abort together with start in IDLE: stay IDLE.
- reset mid-playback: same as the reset values above, with no done pulse.
- seq_len=32: idx runs 0..31; idx never wraps because termination is tested before increment.
- seq_len changes while busy are ignored (len_q is latched).
- The timer is a down-counter loaded on state entry. Its width is clog2(max(ON_CYCLES,OFF_CYCLES,MEM_LATENCY)+1).

Decomposition:
- Package simon_pkg:
  - DATA_W, ADDR_W, MAX_LEN=32.
  - State enum play_state_t {IDLE, READ, WAIT, SHOW, GAP, DONE}.
- One sub-module, cycle_timer:
  - Loadable down-counter with load/value inputs and an expired flag.
  - Reused for WAIT, SHOW and GAP.

Test Plan (bench uses real `memory`, ON_CYCLES=4, OFF_CYCLES=2, MEM_LATENCY=1; preload addr i = 6'b1 << (i%6)):
- start, seq_len=3 -> led_out = 000001 x4, 0 x2, 000010 x4, 0 x2, 000100 x4, 0 x2. r_en pulses at r_ptr 0,1,2. done pulse 25 cycles after the start edge; busy low next cycle.
- start, seq_len=0 -> done the next cycle, r_en never asserted, led_out stays 0.
- start, seq_len=40 -> exactly 32 r_en pulses with r_ptr 0..31, then done; no r_ptr wrap.
- abort asserted during the 2nd SHOW of a seq_len=5 run -> led_out=0 and busy=0 next cycle, no done. A following start with seq_len=1 plays entry 0 only.
- Second start plus a seq_len change during a seq_len=2 run -> ignored; the original 2-entry sequence completes unchanged with a single done.
- reset asserted in the GAP of entry 1 -> next cycle all outputs 0, state IDLE. start afterwards restarts from r_ptr=0.
